// File: rtl/print_stream_arbiter.sv
// print_stream_arbiter
// Collects the UART print byte streams of up to NUM_CORES cores in small
// per-core FIFOs and drains them round-robin into tagged 16-bit words for
// the shared SDK output FIFO, at most one word per cycle, honouring
// fifo_full_i backpressure.
module print_stream_arbiter #(
    parameter int         NUM_CORES = 8,
    parameter int         DEPTH     = 4,
    parameter logic [3:0] TAG       = 4'hC
) (
    input  logic                   SDK_CLK,
    input  logic                   SDK_RSTN,
    input  logic [NUM_CORES-1:0]   core_tf_push_i,
    input  logic [8*NUM_CORES-1:0] core_print_data_i,
    input  logic [NUM_CORES-1:0]   core_enable_i,
    input  logic                   fifo_full_i,
    output logic                   fifo_wr_o,
    output logic [15:0]            fifo_do_o,
    output logic [NUM_CORES-1:0]   overflow_o,
    input  logic                   overflow_clr_i,
    output logic                   busy_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Per-core FIFO storage and bookkeeping
    logic [7:0]    r_mem   [NUM_CORES][DEPTH];
    logic [AW-1:0] r_wptr  [NUM_CORES];
    logic [AW-1:0] r_rptr  [NUM_CORES];
    logic [CW-1:0] r_count [NUM_CORES];

    // Scheduler and output registers
    logic [3:0]           r_last_grant;
    logic                 r_fifo_wr;
    logic [15:0]          r_fifo_do;
    logic [NUM_CORES-1:0] r_overflow;
    logic                 r_busy;

    // Combinational helpers
    logic [NUM_CORES-1:0] w_nonempty;
    logic [NUM_CORES-1:0] w_push;
    logic [NUM_CORES-1:0] w_pop;
    logic [NUM_CORES-1:0] w_accept;
    logic [NUM_CORES-1:0] w_drop;
    logic [CW-1:0]        w_count_nxt [NUM_CORES];
    logic                 w_any_nxt;

    logic                 w_hi_valid;
    logic [3:0]           w_hi_idx;
    logic [7:0]           w_hi_byte;
    logic                 w_lo_valid;
    logic [3:0]           w_lo_idx;
    logic [7:0]           w_lo_byte;
    logic                 w_grant_valid;
    logic [3:0]           w_grant_idx;
    logic [7:0]           w_grant_byte;

    // Eligibility: a core competes for the output when its FIFO holds data
    always_comb begin
        w_nonempty = {NUM_CORES{1'b0}};
        for (int c = 0; c < NUM_CORES; c++) begin
            w_nonempty[c] = (r_count[c] != {CW{1'b0}});
        end
    end

    // Round-robin pick: lowest eligible index above last_grant wins, else
    // the lowest eligible index at or below it (wrap-around); full blocks all
    always_comb begin
        w_hi_valid    = 1'b0;
        w_hi_idx      = 4'd0;
        w_hi_byte     = 8'h00;
        w_lo_valid    = 1'b0;
        w_lo_idx      = 4'd0;
        w_lo_byte     = 8'h00;
        w_grant_valid = 1'b0;
        w_grant_idx   = 4'd0;
        w_grant_byte  = 8'h00;
        // Descending scan so the lowest matching index is the one kept
        for (int c = NUM_CORES - 1; c >= 0; c--) begin
            if (w_nonempty[c]) begin
                if (4'(c) > r_last_grant) begin
                    w_hi_valid = 1'b1;
                    w_hi_idx   = 4'(c);
                    w_hi_byte  = r_mem[c][r_rptr[c]];
                end else begin
                    w_lo_valid = 1'b1;
                    w_lo_idx   = 4'(c);
                    w_lo_byte  = r_mem[c][r_rptr[c]];
                end
            end else begin
                // empty FIFO: earlier candidates stand
            end
        end
        if (fifo_full_i) begin
            w_grant_valid = 1'b0;
        end else if (w_hi_valid) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = w_hi_idx;
            w_grant_byte  = w_hi_byte;
        end else if (w_lo_valid) begin
            w_grant_valid = 1'b1;
            w_grant_idx   = w_lo_idx;
            w_grant_byte  = w_lo_byte;
        end else begin
            w_grant_valid = 1'b0;
        end
    end

    // Per-core push/pop decisions; a pop frees a slot for a same-cycle push
    always_comb begin
        w_push    = {NUM_CORES{1'b0}};
        w_pop     = {NUM_CORES{1'b0}};
        w_accept  = {NUM_CORES{1'b0}};
        w_drop    = {NUM_CORES{1'b0}};
        w_any_nxt = 1'b0;
        for (int c = 0; c < NUM_CORES; c++) begin
            w_count_nxt[c] = r_count[c];
            w_push[c]   = core_tf_push_i[c] & core_enable_i[c];
            w_pop[c]    = w_grant_valid && (w_grant_idx == 4'(c));
            w_accept[c] = w_push[c] && ((r_count[c] < CW'(DEPTH)) || w_pop[c]);
            w_drop[c]   = w_push[c] && !w_accept[c];
            case ({w_accept[c], w_pop[c]})
                2'b10:   w_count_nxt[c] = r_count[c] + CW'(1);
                2'b01:   w_count_nxt[c] = r_count[c] - CW'(1);
                default: w_count_nxt[c] = r_count[c];
            endcase
            w_any_nxt = w_any_nxt | (w_count_nxt[c] != {CW{1'b0}});
        end
    end

    // FIFO storage, pointers (wrap naturally, DEPTH is a power of 2) and counts
    always_ff @(posedge SDK_CLK or negedge SDK_RSTN) begin
        if (!SDK_RSTN) begin
            for (int c = 0; c < NUM_CORES; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    r_mem[c][d] <= 8'h00;
                end
                r_wptr[c]  <= {AW{1'b0}};
                r_rptr[c]  <= {AW{1'b0}};
                r_count[c] <= {CW{1'b0}};
            end
        end else begin
            for (int c = 0; c < NUM_CORES; c++) begin
                if (w_accept[c]) begin
                    r_mem[c][r_wptr[c]] <= core_print_data_i[8*c +: 8];
                    r_wptr[c]           <= r_wptr[c] + AW'(1);
                end
                if (w_pop[c]) begin
                    r_rptr[c] <= r_rptr[c] + AW'(1);
                end
                r_count[c] <= w_count_nxt[c];
            end
        end
    end

    // Scheduler pointer and registered SDK write port; data holds when idle
    always_ff @(posedge SDK_CLK or negedge SDK_RSTN) begin
        if (!SDK_RSTN) begin
            r_last_grant <= 4'(NUM_CORES - 1);
            r_fifo_wr    <= 1'b0;
            r_fifo_do    <= 16'h0000;
        end else begin
            r_fifo_wr <= w_grant_valid;
            if (w_grant_valid) begin
                r_last_grant <= w_grant_idx;
                r_fifo_do    <= {TAG, w_grant_idx, w_grant_byte};
            end
        end
    end

    // Sticky drop flags (a drop beats a simultaneous clear) and busy status
    always_ff @(posedge SDK_CLK or negedge SDK_RSTN) begin
        if (!SDK_RSTN) begin
            r_overflow <= {NUM_CORES{1'b0}};
            r_busy     <= 1'b0;
        end else begin
            r_overflow <= w_drop | (overflow_clr_i ? {NUM_CORES{1'b0}} : r_overflow);
            r_busy     <= w_any_nxt;
        end
    end

    assign fifo_wr_o  = r_fifo_wr;
    assign fifo_do_o  = r_fifo_do;
    assign overflow_o = r_overflow;
    assign busy_o     = r_busy;

endmodule

// File: tb/tb_print_stream_arbiter.sv
// Scoreboard bench for print_stream_arbiter: a queue-based reference model
// predicts each SDK word at the clock edge, a negedge monitor compares.
module tb_print_stream_arbiter;

    localparam int N = 8;
    localparam int D = 4;

    logic           SDK_CLK = 1'b0;
    logic           SDK_RSTN;
    logic [N-1:0]   push;
    logic [8*N-1:0] data;
    logic [N-1:0]   en;
    logic           full;
    logic           clr;
    logic           fifo_wr_o;
    logic [15:0]    fifo_do_o;
    logic [N-1:0]   overflow_o;
    logic           busy_o;

    always #5 SDK_CLK = ~SDK_CLK;

    print_stream_arbiter #(.NUM_CORES(N), .DEPTH(D), .TAG(4'hC)) dut (
        .SDK_CLK           (SDK_CLK),
        .SDK_RSTN          (SDK_RSTN),
        .core_tf_push_i    (push),
        .core_print_data_i (data),
        .core_enable_i     (en),
        .fifo_full_i       (full),
        .fifo_wr_o         (fifo_wr_o),
        .fifo_do_o         (fifo_do_o),
        .overflow_o        (overflow_o),
        .overflow_clr_i    (clr),
        .busy_o            (busy_o)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    logic [7:0]  mq [N][$];
    logic [15:0] exp_q [$];
    int          m_lg;
    logic [N-1:0] m_ovf;
    logic        m_busy;
    logic        m_wr;

    // Observed writes, for directed ordering checks
    logic [15:0] wr_log [$];
    int          wr_cyc [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) mq[i].delete();
        exp_q.delete();
        m_lg   = N - 1;
        m_ovf  = '0;
        m_busy = 1'b0;
        m_wr   = 1'b0;
    endfunction

    function automatic bit model_busy();
        for (int i = 0; i < N; i++) if (mq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the specified behaviour, using the sampled inputs
    function automatic void model_step();
        int g;
        logic [7:0] b;
        g = -1;
        if (!full) begin
            for (int k = 1; k <= N; k++) begin
                int idx;
                idx = (m_lg + k) % N;
                if (g < 0 && mq[idx].size() > 0) g = idx;
            end
        end
        m_wr = (g >= 0);
        if (g >= 0) begin
            b = mq[g].pop_front();
            exp_q.push_back({4'hC, 4'(g), b});
            m_lg = g;
        end
        if (clr) m_ovf = '0;
        for (int i = 0; i < N; i++) begin
            if (push[i] && en[i]) begin
                if (mq[i].size() < D) mq[i].push_back(data[8*i +: 8]);
                else m_ovf[i] = 1'b1;
            end
        end
        m_busy = model_busy();
    endfunction

    // Model advances on every active edge outside reset
    initial begin
        forever begin
            @(posedge SDK_CLK);
            cyc++;
            if (SDK_RSTN === 1'b1) model_step();
        end
    end

    // Monitor: compares outputs against the model away from the active edge
    initial begin
        forever begin
            @(negedge SDK_CLK);
            chk("wr_strobe", 32'(fifo_wr_o), 32'(m_wr));
            if (fifo_wr_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_word unexpected actual=%0h expected=none", fifo_do_o);
                end else begin
                    chk("sb_word", 32'(fifo_do_o), 32'(exp_q.pop_front()));
                end
                wr_log.push_back(fifo_do_o);
                wr_cyc.push_back(cyc);
            end
            chk("busy", 32'(busy_o), 32'(m_busy));
            chk("overflow", 32'(overflow_o), 32'(m_ovf));
        end
    end

    task automatic tick();
        @(posedge SDK_CLK);
        #1;
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while (n < limit && (model_busy() || exp_q.size() != 0)) begin
            tick();
            n++;
        end
        if (n >= limit) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d expected<%0d", n, limit);
        end
        tick();
    endtask

    task automatic do_reset();
        SDK_RSTN = 1'b0;
        model_reset();
        #1;
        chk("reset_wr_async", 32'(fifo_wr_o), 32'd0);
        tick();
        tick();
        SDK_RSTN = 1'b1;
        wr_log.delete();
        wr_cyc.delete();
    endtask

    initial begin
        int exp_core [9];
        exp_core = '{0, 1, 7, 0, 1, 7, 0, 1, 7};
        SDK_RSTN = 1'b0;
        push = '0; data = '0; en = '1; full = 1'b0; clr = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("rst_wr", 32'(fifo_wr_o), 32'd0);
        chk("rst_do", 32'(fifo_do_o), 32'h0000);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        SDK_RSTN = 1'b1;
        tick();

        // Single character, two-edge latency
        push[2] = 1'b1; data[23:16] = 8'h41;
        tick();
        push = '0;
        tick();
        chk("single_wr", 32'(fifo_wr_o), 32'd1);
        chk("single_do", 32'(fifo_do_o), 32'h0000C241);
        chk("single_busy", 32'(busy_o), 32'd0);
        tick();
        chk("single_once", 32'(fifo_wr_o), 32'd0);

        // Fairness from reset: cores 0,1,7 preloaded with three bytes
        do_reset();
        full = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push = 8'b1000_0011;
            data = {$urandom, $urandom};
            tick();
        end
        push = '0;
        full = 1'b0;
        drain(50);
        chk("fair_count", 32'(wr_log.size()), 32'd9);
        if (wr_log.size() == 9) begin
            for (int i = 0; i < 9; i++) begin
                chk("fair_order", 32'(wr_log[i][11:8]), 32'(exp_core[i]));
                chk("fair_consec", 32'(wr_cyc[i] - wr_cyc[0]), 32'(i));
            end
        end

        // Backpressure: two bytes for core 3 held during ten full cycles
        wr_log.delete();
        full = 1'b1;
        push[3] = 1'b1; data[31:24] = 8'h11;
        tick();
        data[31:24] = 8'h22;
        tick();
        push = '0;
        repeat (8) tick();
        chk("bp_no_write", 32'(wr_log.size()), 32'd0);
        full = 1'b0;
        drain(20);
        chk("bp_count", 32'(wr_log.size()), 32'd2);
        if (wr_log.size() == 2) begin
            chk("bp_first", 32'(wr_log[0]), 32'h0000C311);
            chk("bp_second", 32'(wr_log[1]), 32'h0000C322);
        end

        // Overflow: six pushes into a four-deep FIFO while blocked
        wr_log.delete();
        full = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            push[4] = 1'b1;
            data[39:32] = 8'(i);
            tick();
        end
        push = '0;
        chk("ovf_set", 32'(overflow_o[4]), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("ovf_clr", 32'(overflow_o), 32'd0);
        full = 1'b0;
        drain(20);
        chk("ovf_count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("ovf_bytes", 32'(wr_log[i]), 32'h0000C400 + 32'(i + 1));
            end
        end

        // Disabled core ignores pushes without flagging
        wr_log.delete();
        en[5] = 1'b0;
        push[5] = 1'b1;
        data[47:40] = 8'h55;
        tick();
        push = '0;
        en = '1;
        tick();
        tick();
        chk("dis_ovf", 32'(overflow_o[5]), 32'd0);
        chk("dis_no_write", 32'(wr_log.size()), 32'd0);

        // Full FIFO accepts a push when popped in the same cycle
        full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push[6] = 1'b1;
            data[55:48] = 8'h60 + 8'(i);
            tick();
        end
        full = 1'b0;
        data[55:48] = 8'h65;
        tick();
        push = '0;
        chk("simul_ovf", 32'(overflow_o[6]), 32'd0);
        drain(20);
        chk("simul_count", 32'(wr_log.size()), 32'd5);
        if (wr_log.size() == 5) chk("simul_last", 32'(wr_log[4]), 32'h0000C665);

        // Randomised traffic, backpressure and clears
        for (int n = 0; n < 3000; n++) begin
            en   = N'($urandom | $urandom);
            push = N'($urandom & $urandom);
            data = {$urandom, $urandom};
            full = ($urandom_range(0, 3) == 0);
            clr  = ($urandom_range(0, 31) == 0);
            tick();
        end
        push = '0; full = 1'b0; clr = 1'b0;
        drain(200);

        // Reset while three cores are backlogged
        full = 1'b1;
        for (int r = 0; r < 3; r++) begin
            push = 8'b0010_0101;
            data = {$urandom, $urandom};
            tick();
        end
        push = '0;
        full = 1'b0;
        tick();
        #2;
        do_reset();
        repeat (10) tick();
        chk("post_rst_busy", 32'(busy_o), 32'd0);
        chk("post_rst_writes", 32'(wr_log.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/print_stream_arbiter.md
Name: print_stream_arbiter

Overview:
- Shares the single SDK output FIFO between the UART print streams of up to NUM_CORES OpenRISC cores.
- Each core's tf_push/print_data byte stream is buffered in a small per-core FIFO.
- A round-robin scheduler drains the per-core FIFOs into tagged 16-bit SDK words, one word per cycle at most, and stalls on SDK_FIFO_Full.
- Sits between the or1200_sopc instances and the host interface, replacing the core-0-only print path.

Parameters:
- NUM_CORES, 8, number of print requesters (1..16).
- DEPTH, 4, entries per per-core FIFO (power of 2, >=2).
- TAG, 4'hC, constant placed in fifo_do_o[15:12] to mark print words.

Ports:
- SDK_CLK  in  1  system clock, 48 MHz.
- SDK_RSTN  in  1  reset.
- core_tf_push_i  in  NUM_CORES  per-core one-cycle print strobe.
- core_print_data_i  in  8*NUM_CORES  per-core character; core i uses bits [8i+7:8i].
- core_enable_i  in  NUM_CORES  per-core accept mask.
- fifo_full_i  in  1  SDK output FIFO full.
- fifo_wr_o  out  1  SDK FIFO write strobe.
- fifo_do_o  out  16  SDK FIFO data.
- overflow_o  out  NUM_CORES  sticky per-core drop flags.
- overflow_clr_i  in  1  clears all overflow flags.
- busy_o  out  1  any per-core FIFO non-empty.

Behaviour:
- Clock and reset: clock SDK_CLK; reset SDK_RSTN, asynchronous, active-low.
- Reset values: fifo_wr_o=0, fifo_do_o=16'h0000, overflow_o=0, busy_o=0. All FIFO pointers and counts are 0. The round-robin pointer last_grant = NUM_CORES-1, so core 0 has first priority.
- Enqueue, per core i, at each edge:
  - Condition: core_tf_push_i[i] && core_enable_i[i].
  - If count_i<DEPTH, or core i is popped in the same cycle, the byte is written and count updates accordingly.
  - Otherwise the byte is dropped and overflow_o[i] is set.
- Disabled core: pushes are ignored without setting overflow. Entries already queued still drain.
- Grant (combinational, sampled at the edge):
  - eligible = non-empty FIFOs; fifo_full_i=1 blocks the grant entirely.
  - If fifo_full_i=0 and any FIFO is eligible, pick the first eligible index scanning last_grant+1, last_grant+2, ... modulo NUM_CORES.
  - On grant at edge k: pop the head of core g; set last_grant=g; register fifo_wr_o=1 and fifo_do_o={TAG, g[3:0], head byte}, valid in the cycle after edge k.
- No grant: fifo_wr_o=0 and fifo_do_o holds its last value.
- Latency: a push sampled at edge k into an empty FIFO, with fifo_full_i=0 and no competing cores, is popped at edge k+1. fifo_wr_o is high in the cycle following edge k+1.
- Throughput: 1 word/cycle aggregate. With all cores backlogged, each core gets 1 of every NUM_CORES words.
- fifo_full_i is assumed to reflect writes already issued. The block never issues fifo_wr_o in a cycle following a sampled full.
- Per-core ordering is FIFO. Pointers wrap modulo DEPTH.
- Overflow flags: overflow_clr_i=1 clears all flags. A drop in the same cycle as a clear wins, so that flag stays set.
- busy_o is registered: it is 1 when any count is non-zero after the edge.
- Reset mid-operation: all queued bytes are discarded and fifo_wr_o drops to 0 immediately (asynchronous).

Test Plan:
- Single character: core 2 pushes 8'h41 at edge 5, full=0 → fifo_wr_o=1 for exactly one cycle after edge 6, fifo_do_o=16'hC241; busy_o back to 0 after edge 6.
- Fairness: cores 0, 1 and 7 each preload 3 bytes, then the drain is released → write order by core is 0,1,7,0,1,7,0,1,7 with 9 consecutive write cycles.
- Backpressure: fifo_full_i=1 for 10 cycles while core 3 queues 2 bytes → no fifo_wr_o during full. After full drops, 2 writes with bytes in push order.
- Overflow: core 4 pushes 6 bytes on consecutive cycles with full=1, DEPTH=4 → 4 stored, overflow_o[4]=1. overflow_clr_i pulse → overflow_o=0. Drained output is bytes 1-4 only.
- Enable mask and simultaneous events: core_enable_i[5]=0 with push → no write and no overflow. Core 6 full FIFO with push and pop in the same cycle → byte accepted, no overflow.
- Reset mid-stream: assert SDK_RSTN=0 while 3 cores are backlogged → fifo_wr_o=0 immediately. After release, busy_o=0 and no writes occur.
